norm_share_arb: RTL and testbench
=================================

# norm_share_arb

Round-robin arbiter and two-stage pipeline that shares one left_shift_msb normalizer among several HOG datapath clients, e.g. the histogram-normalization and SVM-scaling units. Each client offers a magnitude word. The block grants one word per cycle, normalizes it so its MSB is set, and returns the shifted value and the shift count. The result is tagged with the client index so each client can claim its own result from a single response channel.

## Interface
- NUM_REQ, 4: number of requesters; must be at least 2.
- IN_W, 22: operand width.
- CNT_W, 5: shift-count width; must be at least clog2(IN_W+1).
- ID_W, 2: requester-tag width; must be at least clog2(NUM_REQ).

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester valid.
- req_ready  out  NUM_REQ  per-requester accept. At most one bit is high per cycle.
- req_data  in  NUM_REQ*IN_W  flat operand bus; requester i occupies bits [i*IN_W +: IN_W].
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_data  out  IN_W  normalized operand; its MSB is 1 unless rsp_zero is 1.
- rsp_cnt  out  CNT_W  number of left shifts applied.
- rsp_zero  out  1  operand was all zeros.

## Operation
- Handshake on both sides:
  - A request transfers when req_valid[i] and req_ready[i] are both high.
  - A response transfers when rsp_valid and rsp_ready are both high.
  - Once a requester raises req_valid[i], it holds it and keeps req_data stable until it is accepted.
- Arbitration:
  - Round-robin pointer `ptr` (ID_W bits) is 0 at reset.
  - Grant goes to the first i with req_valid[i]=1, searching ptr, ptr+1, … modulo NUM_REQ.
  - On an accepted grant, ptr becomes grant+1 modulo NUM_REQ. Without an accept, ptr holds.
- Stage A (capture register): holds a_valid, a_id and a_data.
  - Stage A can load when a_valid=0, or when its content moves to stage B this cycle.
  - req_ready[grant] = stage A can load. This is combinational from req_valid, rsp_ready and state.
- Stage B (output register): holds rsp_valid and rsp_*.
  - The left_shift_msb output for a_data loads into stage B when rsp_valid=0 or rsp_ready=1.
- Backpressure:
  - While rsp_valid=1 and rsp_ready=0, stage B holds.
  - Stage A holds if it is full.
  - All req_ready bits are 0 while stage A is full and cannot move.
- Zero operand: rsp_data=0, rsp_cnt=IN_W, rsp_zero=1.
- Operand with MSB already set: rsp_cnt=0, rsp_data equals the operand, rsp_zero=0.
- No request is dropped or duplicated. Results return in accept order.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_cnt=0, rsp_zero=0, a_valid=0, ptr=0. req_ready is 0 during reset.
- Latency: a request accepted at edge N gives rsp_valid=1 after edge N+1.
- Throughput: one result per cycle while rsp_ready stays 1.
- Simultaneous request accept and response accept in the same cycle is legal; the pipeline advances with no bubble.
- Reset asserted mid-operation: all in-flight entries are discarded immediately, with no responses. Operation restarts from ptr=0 on the first edge after rst_n deasserts.
- rsp_* stay stable while rsp_valid=1 and rsp_ready=0.

## Structure
- A shared package/header holds:
  - HOG_NORM_IN_W=22 and HOG_NORM_CNT_W=5, used by all left_shift_msb clients;
  - the clog2 helper function used for the ID_W and CNT_W checks.
- Sub-module rr_arbiter, parameterized by NUM_REQ:
  - inputs: req vector, advance strobe;
  - outputs: one-hot grant, encoded grant index;
  - it owns ptr.
- left_shift_msb is instantiated once, between stage A and stage B, and is not modified.
- Everything else stays flat in norm_share_arb: stage registers and ready logic.

## Test plan
- Single request: requester 2 sends 22'h000100 with rsp_ready=1. Expect after 2 edges: rsp_id=2, rsp_data=22'h200000, rsp_cnt=13, rsp_zero=0.
- Zero and MSB-set operands: 22'h0 gives rsp_data=0, rsp_cnt=22, rsp_zero=1. 22'h3FFFFF gives rsp_cnt=0 and unchanged data.
- Fairness: all 4 requesters hold valid for 8 cycles. Grant order is 0,1,2,3,0,1,2,3; rsp_id follows that order; results arrive back-to-back with no bubbles.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles with 3 requesters valid.
  - Exactly 2 requests are accepted, then all req_ready=0, and rsp_* stay stable.
  - After rsp_ready=1, the remaining requests drain in order with nothing lost.
- Reset mid-stream: assert rst_n=0 with both stages full. rsp_valid drops to 0 immediately. After release, requester 3 alone is granted first (ptr=0, first valid from 0 is 3) and its response appears 2 edges later.

Source files
------------

// File: rtl/norm_share_arb_pkg.sv
// Shared constants and helpers for the HOG left_shift_msb clients.
package norm_share_arb_pkg;

  localparam int HOG_NORM_IN_W  = 22;
  localparam int HOG_NORM_CNT_W = 5;

  // Ceiling log2, usable in constant expressions for width checks.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/left_shift_msb.sv
// Normalizer: shifts the operand left until its MSB is set and reports the shift count.
module left_shift_msb #(
  parameter int IN_W  = 22,
  parameter int CNT_W = 5
) (
  input  logic [IN_W-1:0]  din,
  output logic [IN_W-1:0]  dout,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // Ascending scan: the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = CNT_W'(IN_W);
    for (int i = 0; i < IN_W; i++) begin
      if (din[i]) cnt = CNT_W'(IN_W - 1 - i);
    end
    zero = (din == '0);
    dout = din << cnt;
  end

endmodule

// File: rtl/norm_share_arb_rr_arbiter.sv
// Round-robin arbiter; owns the priority pointer, which moves past the winner on advance.
module rr_arbiter
  import norm_share_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  logic [ID_W-1:0] ptr;

  always_comb begin
    int  idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = ID_W'(idx);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ID_W'((int'(gnt_idx) + 1) % NUM_REQ);
    end
  end

endmodule

// File: rtl/norm_share_arb.sv
// Shares one left_shift_msb among NUM_REQ clients: round-robin grant, capture stage A,
// normalizer, output stage B with valid/ready backpressure and a requester tag.
module norm_share_arb
  import norm_share_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = HOG_NORM_IN_W,
  parameter int CNT_W   = HOG_NORM_CNT_W,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [IN_W-1:0]         rsp_data,
  output logic [CNT_W-1:0]        rsp_cnt,
  output logic                    rsp_zero
);

  if (NUM_REQ < 2) begin : g_chk_num
    $error("norm_share_arb: NUM_REQ must be at least 2");
  end
  if (ID_W < clog2(NUM_REQ)) begin : g_chk_id
    $error("norm_share_arb: ID_W too narrow for NUM_REQ");
  end
  if (CNT_W < clog2(IN_W + 1)) begin : g_chk_cnt
    $error("norm_share_arb: CNT_W too narrow for IN_W");
  end

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic [IN_W-1:0]    sel_data;

  logic               a_valid;
  logic [ID_W-1:0]    a_id;
  logic [IN_W-1:0]    a_data;

  logic [IN_W-1:0]    ls_data;
  logic [CNT_W-1:0]   ls_cnt;
  logic               ls_zero;

  logic               b_load;
  logic               a_move;
  logic               a_can_load;
  logic               accept;

  // Stage B refills whenever it is empty or being drained; A moves along with it.
  assign b_load     = !rsp_valid || rsp_ready;
  assign a_move     = a_valid && b_load;
  assign a_can_load = !a_valid || a_move;
  assign req_ready  = (rst_n && a_can_load) ? gnt : '0;
  assign accept     = |(req_valid & req_ready);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) sel_data = req_data[i*IN_W +: IN_W];
    end
  end

  // Stage A: capture the granted operand
  always_ff @(posedge clk) begin
    if (accept) begin
      a_id   <= gnt_idx;
      a_data <= sel_data;
    end
  end

  left_shift_msb #(
    .IN_W  (IN_W),
    .CNT_W (CNT_W)
  ) u_norm (
    .din  (a_data),
    .dout (ls_data),
    .cnt  (ls_cnt),
    .zero (ls_zero)
  );

  // Stage B: register the normalized result and its owner tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_cnt   <= '0;
      rsp_zero  <= 1'b0;
    end else begin
      if (accept) begin
        a_valid <= 1'b1;
      end else if (a_move) begin
        a_valid <= 1'b0;
      end
      if (b_load) begin
        rsp_valid <= a_valid;
        if (a_valid) begin
          rsp_id   <= a_id;
          rsp_data <= ls_data;
          rsp_cnt  <= ls_cnt;
          rsp_zero <= ls_zero;
        end
      end
    end
  end

endmodule

// File: tb/tb_norm_share_arb.sv
// Randomized bench for norm_share_arb with a queue-based reference model and directed scenarios.
module tb_norm_share_arb;
  localparam int NUM_REQ = 4;
  localparam int IN_W    = 22;
  localparam int CNT_W   = 5;
  localparam int ID_W    = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*IN_W-1:0] req_data;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [IN_W-1:0]         rsp_data;
  logic [CNT_W-1:0]        rsp_cnt;
  logic                    rsp_zero;

  norm_share_arb #(
    .NUM_REQ (NUM_REQ),
    .IN_W    (IN_W),
    .CNT_W   (CNT_W),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_cnt   (rsp_cnt),
    .rsp_zero  (rsp_zero)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference normalizer: double the value until it reaches the top half of the range.
  function automatic void ref_norm(input logic [IN_W-1:0] d, output logic [IN_W-1:0] o,
                                   output int c);
    longint v;
    v = longint'(d);
    c = 0;
    o = '0;
    if (v == 0) begin
      c = IN_W;
    end else begin
      while (v < (longint'(1) << (IN_W - 1))) begin
        v = v * 2;
        c++;
      end
      o = IN_W'(v);
    end
  endfunction

  typedef struct {
    int              id;
    logic [IN_W-1:0] data;
    int              cnt;
    bit              zero;
    int              stamp;
  } item_t;

  item_t q[$];
  int    m_ptr = 0;
  int    cyc   = 0;

  // Reference model: checks at the falling edge, then advances by one clock.
  always @(negedge clk) begin
    int              g;
    logic [NUM_REQ-1:0] er;
    bit              ev;
    item_t           it;
    logic [IN_W-1:0] op;
    logic [IN_W-1:0] o;
    int              c;
    if (!rst_n) begin
      q.delete();
      m_ptr = 0;
      cyc   = 0;
      check_val("ready_in_reset", 32'(req_ready), 32'(0));
      check_val("rsp_valid_in_reset", 32'(rsp_valid), 32'(0));
    end else begin
      g = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
      end
      er = '0;
      if (g >= 0 && !(q.size() == 2 && !rsp_ready)) er[g] = 1'b1;
      check_val("req_ready", 32'(req_ready), 32'(er));
      ev = (q.size() > 0) && (cyc >= q[0].stamp + 2);
      check_val("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev && rsp_valid) begin
        check_val("rsp_id", 32'(rsp_id), 32'(q[0].id));
        check_val("rsp_data", 32'(rsp_data), 32'(q[0].data));
        check_val("rsp_cnt", 32'(rsp_cnt), 32'(q[0].cnt));
        check_val("rsp_zero", 32'(rsp_zero), 32'(q[0].zero));
      end
      if (ev && rsp_ready) void'(q.pop_front());
      if (g >= 0 && er[g]) begin
        op = req_data[g*IN_W +: IN_W];
        ref_norm(op, o, c);
        it.id    = g;
        it.data  = o;
        it.cnt   = c;
        it.zero  = (op == '0);
        it.stamp = cyc;
        q.push_back(it);
        m_ptr = (g + 1) % NUM_REQ;
      end
      cyc++;
    end
  end

  logic [NUM_REQ-1:0] refill;
  logic [NUM_REQ-1:0] last_acc;

  function automatic logic [IN_W-1:0] rnd_op();
    logic [IN_W-1:0] r;
    case ($urandom_range(0, 4))
      0:       r = '0;
      1:       r = {1'b1, (IN_W-1)'($urandom)};
      2:       r = IN_W'(1) << $urandom_range(0, IN_W - 1);
      default: r = IN_W'($urandom) >> $urandom_range(0, IN_W - 1);
    endcase
    return r;
  endfunction

  task automatic drive(input int i, input logic [IN_W-1:0] v);
    req_valid[i] = 1'b1;
    req_data[i*IN_W +: IN_W] = v;
  endtask

  // One clock: note accepts at the falling edge, then update requesters after the rising edge.
  task automatic step();
    logic [NUM_REQ-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    last_acc = acc;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        if (refill[i]) drive(i, rnd_op());
        else req_valid[i] = 1'b0;
      end
    end
  endtask

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
    if ($countones(v) != 1) r = -1;
    return r;
  endfunction

  initial begin
    int nacc;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    refill    = '0;
    last_acc  = '0;
    for (int i = 0; i < NUM_REQ; i++) drive(i, rnd_op());
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_rsp_id", 32'(rsp_id), 32'(0));
    check_val("reset_rsp_data", 32'(rsp_data), 32'(0));
    check_val("reset_rsp_cnt", 32'(rsp_cnt), 32'(0));
    check_val("reset_rsp_zero", 32'(rsp_zero), 32'(0));
    req_valid = '0;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    step();

    // single request from requester 2
    drive(2, 22'h000100);
    step();
    step();
    check_val("single_valid", 32'(rsp_valid), 32'(1));
    check_val("single_id", 32'(rsp_id), 32'(2));
    check_val("single_data", 32'(rsp_data), 32'h200000);
    check_val("single_cnt", 32'(rsp_cnt), 32'(13));
    check_val("single_zero", 32'(rsp_zero), 32'(0));

    drive(0, 22'h0);
    step();
    step();
    check_val("zero_data", 32'(rsp_data), 32'(0));
    check_val("zero_cnt", 32'(rsp_cnt), 32'(22));
    check_val("zero_flag", 32'(rsp_zero), 32'(1));

    drive(1, 22'h3FFFFF);
    step();
    step();
    check_val("msb_data", 32'(rsp_data), 32'h3FFFFF);
    check_val("msb_cnt", 32'(rsp_cnt), 32'(0));
    check_val("msb_zero", 32'(rsp_zero), 32'(0));

    // fairness from a fresh pointer
    rst_n = 1'b0;
    step();
    step();
    rst_n  = 1'b1;
    refill = '1;
    for (int i = 0; i < NUM_REQ; i++) drive(i, rnd_op());
    for (int k = 0; k < 8; k++) begin
      step();
      check_val("fair_grant", 32'(onehot_idx(last_acc)), 32'(k % NUM_REQ));
    end
    refill    = '0;
    req_valid = '0;
    repeat (3) step();

    // backpressure with three requesters
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, rnd_op());
    nacc = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      nacc += $countones(last_acc);
    end
    check_val("bp_accepts", 32'(nacc), 32'(2));
    @(negedge clk);
    check_val("bp_ready_low", 32'(req_ready), 32'(0));
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (nacc == 3 && q.size() == 0) break;
      step();
      nacc += $countones(last_acc);
    end
    check_val("bp_drained", 32'(nacc), 32'(3));

    // reset with both stages full
    rsp_ready = 1'b0;
    drive(0, rnd_op());
    drive(1, rnd_op());
    repeat (3) step();
    check_val("pre_reset_valid", 32'(rsp_valid), 32'(1));
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    check_val("reset_drop", 32'(rsp_valid), 32'(0));
    step();
    step();
    drive(3, 22'h000001);
    rsp_ready = 1'b1;
    rst_n     = 1'b1;
    step();
    check_val("post_reset_grant", 32'(onehot_idx(last_acc)), 32'(3));
    step();
    check_val("post_reset_valid", 32'(rsp_valid), 32'(1));
    check_val("post_reset_id", 32'(rsp_id), 32'(3));
    check_val("post_reset_cnt", 32'(rsp_cnt), 32'(21));

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 9) < 4) drive(i, rnd_op());
      end
      step();
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (q.size() == 0 && req_valid == '0) break;
      step();
    end
    check_val("drain_pending_req", 32'(req_valid), 32'(0));
    check_val("drain_queue", 32'(q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
